// File: rtl/lmsm_pkg.sv
// Shared state encoding, default widths and mask helpers for the load/store-multiple sequencer.
package lmsm_pkg;

    localparam int LMSM_DATA_W = 16;
    localparam int LMSM_NREG   = 8;
    localparam int LMSM_IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } lmsm_state_e;

    function automatic logic [LMSM_IDX_W:0] mask_popcount(input logic [LMSM_NREG-1:0] mask);
        logic [LMSM_IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < LMSM_NREG; i++) begin
            cnt = cnt + {{LMSM_IDX_W{1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lsb_prio_enc8.sv
// Lowest-set-bit priority encoder for an 8-bit register mask; valid is 0 for an empty mask.
module lsb_prio_enc8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       valid
);

    // Lowest index wins so transfers run in ascending register order.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b1;
        casez (mask)
            8'b???????1: idx = 3'd0;
            8'b??????10: idx = 3'd1;
            8'b?????100: idx = 3'd2;
            8'b????1000: idx = 3'd3;
            8'b???10000: idx = 3'd4;
            8'b??100000: idx = 3'd5;
            8'b?1000000: idx = 3'd6;
            8'b10000000: idx = 3'd7;
            default: begin
                idx   = 3'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: one memory transfer per set mask bit at consecutive addresses.
// Optional macro LMSM_END_ADDR_EN adds the registered end_addr output.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int DATA_W = LMSM_DATA_W,
    parameter int NREG   = LMSM_NREG,
    parameter int IDX_W  = LMSM_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [DATA_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  rf_sel,
    output logic              rf_write_n,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [IDX_W:0]    xfer_cnt
`ifdef LMSM_END_ADDR_EN
    ,
    output logic [DATA_W-1:0] end_addr
`endif
);

    localparam logic [DATA_W-1:0] PTR_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]    CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    lmsm_state_e       state_r;
    logic [NREG-1:0]   rem_mask_r;
    logic [NREG-1:0]   next_mask_s;
    logic [DATA_W-1:0] ptr_r;
    logic              load_r;
    logic [IDX_W-1:0]  sel_r;
    logic [IDX_W-1:0]  enc_idx_s;
    logic              enc_valid_s;
    logic              busy_r;
    logic              done_r;
    logic              rf_write_n_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [DATA_W-1:0] rf_wdata_r;
    logic [IDX_W:0]    xfer_cnt_r;

    lsb_prio_enc8 u_enc (
        .mask  (rem_mask_r),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    // Remaining mask once the register currently being transferred is retired.
    always_comb begin
        next_mask_s            = rem_mask_r;
        next_mask_s[enc_idx_s] = 1'b0;
    end

    // Sequencer FSM; every control output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rem_mask_r   <= '0;
            ptr_r        <= '0;
            load_r       <= 1'b0;
            sel_r        <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rf_write_n_r <= 1'b1;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            rf_wdata_r   <= '0;
            xfer_cnt_r   <= '0;
        end else begin
            done_r       <= 1'b0;
            rf_write_n_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        rem_mask_r <= reg_mask;
                        ptr_r      <= base_addr;
                        load_r     <= is_load;
                        xfer_cnt_r <= '0;
                        busy_r     <= 1'b1;
                        if (reg_mask == '0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_REQ;
                            mem_req_r <= 1'b1;
                            mem_we_r  <= ~is_load;
                        end
                    end else begin
                        busy_r    <= 1'b0;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack && enc_valid_s) begin
                        rem_mask_r <= next_mask_s;
                        ptr_r      <= ptr_r + PTR_ONE;
                        xfer_cnt_r <= xfer_cnt_r + CNT_ONE;
                        sel_r      <= enc_idx_s;
                        if (load_r) begin
                            rf_wdata_r   <= mem_rdata;
                            rf_write_n_r <= 1'b0;
                            mem_req_r    <= 1'b0;
                            mem_we_r     <= 1'b0;
                            state_r      <= ST_WB;
                        end else if (next_mask_s == '0) begin
                            mem_req_r <= 1'b0;
                            mem_we_r  <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            state_r <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WB: begin
                    if (rem_mask_r == '0) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        mem_req_r <= 1'b1;
                        mem_we_r  <= ~load_r;
                        state_r   <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LMSM_END_ADDR_EN
    logic [DATA_W-1:0] end_addr_r;

    // End address is fixed at accept time and held until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            end_addr_r <= '0;
        end else if (state_r == ST_IDLE && start) begin
            end_addr_r <= base_addr + DATA_W'(mask_popcount(reg_mask));
        end else begin
            end_addr_r <= end_addr_r;
        end
    end

    assign end_addr = end_addr_r;
`endif

    // rf_sel follows the encoder while requesting, and the retired index through write-back.
    assign rf_sel     = (state_r == ST_REQ) ? enc_idx_s : sel_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign rf_write_n = rf_write_n_r;
    assign rf_wdata   = rf_wdata_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = ptr_r;
    assign mem_wdata  = (mem_req_r && mem_we_r) ? rf_rdata : '0;
    assign xfer_cnt   = xfer_cnt_r;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: vector table plus scoreboard of expected transfers.
// Checks end_addr as well when LMSM_END_ADDR_EN is defined.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [7:0]  reg_mask = 8'h00;
    logic [15:0] base_addr = 16'h0000;
    logic        busy, done, rf_write_n, mem_req, mem_we, mem_ack;
    logic [2:0]  rf_sel;
    logic [15:0] rf_wdata, rf_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  xfer_cnt;
`ifdef LMSM_END_ADDR_EN
    logic [15:0] end_addr;
`endif

    typedef struct {
        logic        ld;
        logic [2:0]  idx;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        logic        ld;
        logic [7:0]  mask;
        logic [15:0] base;
        int          dly;
        int          lat;
        int          xfer;
        logic [15:0] end_a;
    } vec_t;

    ev_t         sb[$];
    vec_t        vecs[6];
    logic [15:0] regs[8];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        ack_force = 1'b0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_a = 16'h0000;

    lmsm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .reg_mask(reg_mask), .base_addr(base_addr), .busy(busy), .done(done),
        .rf_sel(rf_sel), .rf_write_n(rf_write_n), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .xfer_cnt(xfer_cnt)
`ifdef LMSM_END_ADDR_EN
        , .end_addr(end_addr)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (a == 16'h0040) return 16'hAAAA;
        else if (a == 16'h0041) return 16'hBBBB;
        else return {a[7:0] ^ 8'hC3, a[7:0]};
    endfunction

    assign mem_rdata = mem_val(mem_addr);
    assign rf_rdata  = regs[rf_sel];
    assign mem_ack   = ack_force | (mem_req && (wait_cnt >= ack_delay));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset || !mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transfer monitor: SM writes at the accepting ack, LM at the write strobe.
    always @(negedge clk) begin : mon
        ev_t e;
        if (reset) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && mem_req) chk("addr_hold", mem_addr, hold_a);
            hold_v <= mem_req && !mem_ack;
            hold_a <= mem_addr;
            if (mem_req && mem_ack && mem_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_store", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("store_kind", 0, e.ld);
                    chk("store_sel", rf_sel, e.idx);
                    chk("store_addr", mem_addr, e.addr);
                    chk("store_data", mem_wdata, e.data);
                end
            end
            if (!rf_write_n) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("load_kind", 1, e.ld);
                    chk("load_sel", rf_sel, e.idx);
                    chk("load_data", rf_wdata, e.data);
                    chk("load_no_req", mem_req, 0);
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic [7:0] mask, input logic [15:0] base, input int dly);
        ev_t e;
        int  n;
        n = 0;
        @(posedge clk); #1;
        ack_delay = dly;
        start = 1'b1; is_load = ld; reg_mask = mask; base_addr = base;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                e.ld   = ld;
                e.idx  = 3'(i);
                e.addr = base + 16'(n);
                e.data = ld ? mem_val(e.addr) : regs[i];
                sb.push_back(e);
                n++;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string name, input int lat, input int xfer, input logic [15:0] end_a);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            chk($sformatf("%s_timeout", name), 0, 1);
        end else begin
            chk($sformatf("%s_lat", name), cyc - t0 + 1, lat);
            chk($sformatf("%s_xfer", name), xfer_cnt, xfer);
            chk($sformatf("%s_busy_done", name), busy, 1);
`ifdef LMSM_END_ADDR_EN
            chk($sformatf("%s_end_addr", name), end_addr, end_a);
`endif
            $display("op %s complete, end address %h", name, end_a);
        end
        @(posedge clk); #1;
        chk($sformatf("%s_done_pulse", name), done, 0);
        chk($sformatf("%s_idle", name), busy, 0);
        chk($sformatf("%s_sb_empty", name), sb.size(), 0);
        sb.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk($sformatf("%s_busy", tag), busy, 0);
        chk($sformatf("%s_done", tag), done, 0);
        chk($sformatf("%s_write_n", tag), rf_write_n, 1);
        chk($sformatf("%s_mem_req", tag), mem_req, 0);
        chk($sformatf("%s_mem_we", tag), mem_we, 0);
        chk($sformatf("%s_rf_sel", tag), rf_sel, 0);
        chk($sformatf("%s_mem_addr", tag), mem_addr, 0);
        chk($sformatf("%s_rf_wdata", tag), rf_wdata, 0);
        chk($sformatf("%s_xfer_cnt", tag), xfer_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        regs[0] = 16'h0011; regs[1] = 16'h0F01; regs[2] = 16'h0022; regs[3] = 16'h0F03;
        regs[4] = 16'h0F04; regs[5] = 16'h0055; regs[6] = 16'h0F06; regs[7] = 16'h0077;

        vecs[0] = '{1'b0, 8'hA5, 16'h0100, 0, 5, 4, 16'h0104};
        vecs[1] = '{1'b1, 8'h0A, 16'h0040, 2, 9, 2, 16'h0042};
        vecs[2] = '{1'b0, 8'h00, 16'h1234, 0, 1, 0, 16'h1234};
        vecs[3] = '{1'b1, 8'hFF, 16'hFFFE, 0, 17, 8, 16'h0006};
        vecs[4] = '{1'b0, 8'h80, 16'h0300, 1, 3, 1, 16'h0301};
        vecs[5] = '{1'b1, 8'h01, 16'h7FFF, 0, 3, 1, 16'h8000};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
`ifdef LMSM_END_ADDR_EN
        chk("reset_end_addr", end_addr, 0);
`endif
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].ld, vecs[v].mask, vecs[v].base, vecs[v].dly);
            wait_done($sformatf("vec%0d", v), vecs[v].lat, vecs[v].xfer, vecs[v].end_a);
        end

        // Ack while idle must not start anything.
        ack_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ack_force = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_sb", sb.size(), 0);

        // Reset during the second LM transfer aborts without further strobes.
        issue(1'b1, 8'h0F, 16'h0500, 2);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("abort");
        chk("abort_sb_left", sb.size(), 3);
        sb.delete();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_quiet", busy, 0);
        issue(1'b1, 8'h0F, 16'h0500, 0);
        wait_done("after_abort", 9, 4, 16'h0504);

        // A start while busy must not disturb the running operation.
        issue(1'b1, 8'h06, 16'h0200, 1);
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b0; reg_mask = 8'hF0; base_addr = 16'h9999;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart_ignored", 7, 2, 16'h0202);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Load-multiple/store-multiple sequencer. Sits directly upstream of the 8x16 register file.
- Walks an 8-bit register mask and issues one memory transfer per set bit at consecutive addresses.
- Load (LM): drives the register file write port (index, data, active-low write strobe).
- Store (SM): drives the register file read address and forwards the read data to memory.

Parameters:
- DATA_W, 16, data and address width.
- NREG, 8, number of architectural registers; equals the mask width.
- IDX_W, 3, register index width; equals log2(NREG).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_load  in  1  1 = LM (memory to regs), 0 = SM (regs to memory); latched on start.
- reg_mask  in  NREG  set bits select registers; latched on start.
- base_addr  in  DATA_W  first memory address; latched on start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- rf_sel  out  IDX_W  current register index; feeds write_select (LM) and readAdd (SM).
- rf_write_n  out  1  active-low register file write strobe.
- rf_wdata  out  DATA_W  register file write data.
- rf_rdata  in  DATA_W  register file read data at rf_sel (combinational read).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable (1 = store).
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  transfer complete; may assert in the same cycle as mem_req.
- xfer_cnt  out  IDX_W+1  transfers completed in the current operation.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous, active-high, named reset.
  - Reset values: state IDLE; busy=0; done=0; rf_write_n=1; mem_req=0; mem_we=0; rf_sel=0; mem_addr=0; rf_wdata=0; xfer_cnt=0.
- States: IDLE, REQ, WB, DONE.
- IDLE:
  - On start=1: latch mask into rem_mask, base_addr into ptr, and is_load; clear xfer_cnt.
  - rem_mask==0 -> DONE, so done pulses 1 cycle after start with no transfers.
  - Otherwise -> REQ.
- REQ:
  - rf_sel = index of the lowest set bit of rem_mask (combinational priority encode).
  - Drive mem_req=1, mem_addr=ptr, mem_we=~is_load.
  - For SM, mem_wdata=rf_rdata (pass-through).
  - Hold every output stable until mem_ack.
- REQ on mem_ack:
  - Clear bit rf_sel in rem_mask; ptr<=ptr+1, wrapping 16'hFFFF->16'h0000; xfer_cnt<=xfer_cnt+1.
  - LM: rf_wdata<=mem_rdata; hold rf_sel for WB -> WB.
  - SM: updated rem_mask==0 -> DONE; else REQ.
- WB:
  - rf_write_n=0 for exactly this cycle; mem_req=0.
  - Then updated rem_mask==0 -> DONE; else REQ.
- DONE: done=1 and busy=1 for one cycle -> IDLE.
- Throughput with zero-wait ack: SM one cycle per register; LM two cycles per register.
- Transfer order is strictly ascending register index.
- start while not IDLE: ignored; latched state is unchanged.
- reset mid-operation: abort immediately. No further write strobe or mem_req; rem_mask is discarded.
- rf_write_n is never low outside WB; it is never low for SM.
- mem_ack outside REQ: ignored.

Optional Feature:
- Macro LMSM_END_ADDR_EN.
- Defined:
  - Adds output end_addr (DATA_W), equal to base_addr + popcount(reg_mask), mod 2^16.
  - Registered; valid when done=1 and held until the next accepted start; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package lmsm_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, WB=2'd2, DONE=2'd3);
  - DATA_W, NREG, IDX_W defaults.
- One sub-module, lsb_prio_enc8:
  - input: 8-bit mask;
  - outputs: 3-bit index of the lowest set bit, plus a valid flag (0 when mask==0).

Test Plan:
- SM, mask=8'b1010_0101, base=16'h0100, regs r0=0x11, r2=0x22, r5=0x55, r7=0x77, zero-wait ack -> writes (0x0100,0x11), (0x0101,0x22), (0x0102,0x55), (0x0103,0x77). done 5 cycles after start; xfer_cnt=4; rf_write_n stays 1.
- LM, mask=8'b0000_1010, base=16'h0040, mem[0x40]=0xAAAA, mem[0x41]=0xBBBB, ack delayed 2 cycles -> rf_write_n low once with rf_sel=1, data 0xAAAA; then once with rf_sel=3, data 0xBBBB. mem_addr held stable while waiting.
- mask=8'h00 -> done exactly 1 cycle after start; mem_req never asserted; xfer_cnt=0.
- LM, mask=8'hFF, base=16'hFFFE -> addresses FFFE, FFFF, 0000 ... 0005; 8 write strobes in index order 0..7; end_addr=16'h0006 when LMSM_END_ADDR_EN is defined.
- reset asserted during the second transfer of LM mask=8'h0F -> next cycle IDLE, all outputs at reset values, no further strobes; a new start afterwards executes normally.
- start re-pulsed while busy with a different mask -> ignored; the original transfer sequence completes unchanged.
